wide_add_seq: RTL and testbench
===============================

Name: wide_add_seq

Overview:
- Multi-cycle sequencer that performs WORDS×32-bit add/subtract by driving one external 32-bit ripple-carry adder (rca32) one limb per cycle, least-significant limb first.
- Holds the inter-limb carry in a register and assembles the full-width result with carry-out and signed-overflow flags.
- Sits between the ALU control path and the shared rca32 instance, so wide arithmetic needs no wider adder.

Parameters:
- WORDS, 2, number of 32-bit limbs; operand width N = 32*WORDS; legal range 2..16.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- sub  in  1  0 = A+B, 1 = A−B; latched with start.
- op_a  in  N  operand A; latched with start.
- op_b  in  N  operand B; latched with start.
- busy  out  1  high while limbs are being processed (RUN state).
- done  out  1  one-cycle pulse: result and flags are valid.
- result  out  N  sum/difference; held until the next accepted start.
- cout  out  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.
- add_a  out  32  limb of A driven to rca32.
- add_b  out  32  limb of B, inverted when sub=1, driven to rca32.
- add_cin  out  1  carry-in driven to rca32.
- add_s  in  32  rca32 sum, combinational from add_a/add_b/add_cin.
- add_cout  in  1  rca32 carry-out.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0, limb index=0, carry register=0. Reset in any state, including mid-RUN, aborts the operation and discards partial results.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1:
  - latch op_a, op_b, sub;
  - idx←0, carry←sub (the +1 for two's-complement subtract);
  - result←0; go to RUN.
- start while busy=1 is ignored; no queuing.
- RUN, each cycle, combinationally:
  - add_a = A[32*idx +: 32];
  - add_b = sub ? ~B[32*idx +: 32] : B[32*idx +: 32];
  - add_cin = carry.
- RUN, at each edge: result[32*idx +: 32]←add_s, carry←add_cout, idx←idx+1.
- Final limb (idx=WORDS−1), at the same edge:
  - cout←add_cout;
  - ovf←(add_a[31] == add_b[31]) && (add_s[31] != add_a[31]), using the effective B;
  - go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE unless start=1, in which case the new operation is accepted (back-to-back).
- Latency: start accepted at edge E0 → busy high for WORDS cycles → done high in the cycle after edge E_WORDS. Throughput is one operation per WORDS+1 cycles; back-to-back start in DONE gives WORDS+1.
- add_a, add_b and add_cin are 0 outside RUN.
- result, cout and ovf change only at a final-limb capture or on reset. They hold stable in IDLE. They are cleared to 0 at start acceptance only for result, not for the flags.
- The limb index register is max(1, clog2(WORDS)) bits wide; it does not wrap during RUN because the FSM leaves RUN at WORDS−1.

Optional Feature:
- Macro: WIDE_ADD_SAT_EN.
- With the macro defined: when the final-limb ovf condition holds, result is written with signed saturation instead of the wrapped value:
  - 0x7FF…F when add_a[31]=0;
  - 0x800…0 when add_a[31]=1.
  - ovf is still set and cout is unchanged.
- Without the macro: result is always the wrapped modulo-2^N value.

Test Plan:
- WORDS=2, A=0x00000000_FFFFFFFF, B=1, sub=0 → busy 2 cycles, done pulse; result=0x00000001_00000000, cout=0, ovf=0; add_cin=1 on limb 1.
- A=0, B=1, sub=1 → result=0xFFFFFFFF_FFFFFFFF, cout=0 (borrow), ovf=0. Also A=5, B=5, sub=1 → result=0, cout=1.
- A=0x7FFFFFFF_FFFFFFFF, B=1, sub=0 → result=0x80000000_00000000, ovf=1, cout=0. With WIDE_ADD_SAT_EN: result=0x7FFFFFFF_FFFFFFFF, ovf=1.
- start pulsed in cycle 1 of RUN with different operands → ignored, first result unchanged. start held high in the DONE cycle → second operation begins next edge, done recurs 3 cycles later.
- rst asserted after limb 0 is captured → next cycle busy=0, done=0, result=0, cout=0, ovf=0, add_* = 0. A fresh A=3, B=4 add then yields 7.

Source files
------------

// File: rtl/wide_add_seq_if.sv
// Request/result and rca32 bus bundle for wide_add_seq.
// slave = sequencer side, master = ALU control plus the shared adder.
interface wide_add_seq_if #(
    parameter int WORDS = 2
);
    localparam int N = 32 * WORDS;

    logic         start;
    logic         sub;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         cout;
    logic         ovf;
    logic [31:0]  add_a;
    logic [31:0]  add_b;
    logic         add_cin;
    logic [31:0]  add_s;
    logic         add_cout;

    modport slave (
        input  start, sub, op_a, op_b, add_s, add_cout,
        output busy, done, result, cout, ovf, add_a, add_b, add_cin
    );

    modport master (
        output start, sub, op_a, op_b, add_s, add_cout,
        input  busy, done, result, cout, ovf, add_a, add_b, add_cin
    );
endinterface

// File: rtl/wide_add_seq.sv
// WORDS x 32-bit add/subtract sequenced one limb per cycle through an external rca32.
// Optional macro WIDE_ADD_SAT_EN: saturate the result on signed overflow.
module wide_add_seq #(
    parameter int WORDS = 2
) (
    input  logic          clk,
    input  logic          rst,
    wide_add_seq_if.slave bus
);
    localparam int N     = 32 * WORDS;
    localparam int IDX_W = (WORDS <= 2) ? 1 : $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic                    carry;
    logic [WORDS-1:0][31:0]  a_lat;
    logic [WORDS-1:0][31:0]  b_lat;
    logic                    sub_lat;
    logic [WORDS-1:0][31:0]  result;
    logic                    cout;
    logic                    ovf;
    logic                    busy;
    logic                    done;

    logic [31:0]             add_a;
    logic [31:0]             add_b;
    logic                    add_cin;
    logic                    ovf_now;

`ifdef WIDE_ADD_SAT_EN
    function automatic logic [N-1:0] sat_limit(input logic neg);
        sat_limit = neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    endfunction
`endif

    // Adder bus is only driven while a limb is in flight.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_lat[idx];
            add_b   = sub_lat ? ~b_lat[idx] : b_lat[idx];
            add_cin = carry;
        end
    end

    // Signed overflow judged on the top limb with the effective (possibly inverted) B.
    assign ovf_now = (add_a[31] == add_b[31]) && (bus.add_s[31] != add_a[31]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        a_lat   <= bus.op_a;
                        b_lat   <= bus.op_b;
                        sub_lat <= bus.sub;
                        idx     <= '0;
                        carry   <= bus.sub;
                        result  <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    result[idx] <= bus.add_s;
                    carry       <= bus.add_cout;
                    idx         <= idx + 1'b1;
                    if (idx == LAST) begin
                        cout  <= bus.add_cout;
                        ovf   <= ovf_now;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
`ifdef WIDE_ADD_SAT_EN
                        if (ovf_now) begin
                            result <= sat_limit(add_a[31]);
                        end
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.add_a   = add_a;
    assign bus.add_b   = add_b;
    assign bus.add_cin = add_cin;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.result  = result;
    assign bus.cout    = cout;
    assign bus.ovf     = ovf;
endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq: directed scenarios plus random operands
// against a full-width arithmetic reference model; the bench also plays rca32.
module tb_wide_add_seq;
    localparam int W = 2;
    localparam int N = 32 * W;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    wide_add_seq_if #(.WORDS(W)) bus ();

    wide_add_seq #(.WORDS(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'd0, bus.add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: full-width unsigned/signed arithmetic, independent of limbs.
    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                                  output logic [N-1:0] r, output logic c, output logic v);
        logic [N:0]        u;
        logic signed [N:0] ext;
        if (s) begin
            u   = {1'b0, a} - {1'b0, b};
            c   = (a >= b);
            ext = $signed({a[N-1], a}) - $signed({b[N-1], b});
        end else begin
            u   = {1'b0, a} + {1'b0, b};
            c   = u[N];
            ext = $signed({a[N-1], a}) + $signed({b[N-1], b});
        end
        v = (ext[N] != ext[N-1]);
        r = u[N-1:0];
`ifdef WIDE_ADD_SAT_EN
        if (v) r = ext[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
    endfunction

    // Carry into limb k = carry out of the low 32*k bits of A + effective B + sub.
    function automatic logic cin_at(input logic [N-1:0] a, input logic [N-1:0] b, input logic s, input int k);
        logic [N-1:0] m;
        logic [N-1:0] be;
        logic [N:0]   lo;
        if (k == 0) return s;
        m  = {N{1'b1}} >> (N - 32 * k);
        be = s ? ~b : b;
        lo = {1'b0, a & m} + {1'b0, be & m} + {{N{1'b0}}, s};
        return lo[32 * k];
    endfunction

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s, input string tag);
        logic [N-1:0] er;
        logic         ec;
        logic         ev;
        logic [31:0]  bl;
        int           n;
        model(a, b, s, er, ec, ev);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.sub   = s;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        n = 0;
        while (bus.busy && n < 4 * W) begin
            bl = s ? ~b[32*n +: 32] : b[32*n +: 32];
            check({tag, "_add_a"}, N'(bus.add_a), N'(a[32*n +: 32]));
            check({tag, "_add_b"}, N'(bus.add_b), N'(bl));
            check({tag, "_add_cin"}, N'(bus.add_cin), N'(cin_at(a, b, s, n)));
            n++;
            tick;
        end
        check({tag, "_busy_cycles"}, N'(n), N'(W));
        check({tag, "_done"}, N'(bus.done), N'(1'b1));
        check({tag, "_result"}, bus.result, er);
        check({tag, "_cout"}, N'(bus.cout), N'(ec));
        check({tag, "_ovf"}, N'(bus.ovf), N'(ev));
        tick;
        check({tag, "_done_drop"}, N'(bus.done), N'(1'b0));
        check({tag, "_hold"}, bus.result, er);
    endtask

    task automatic check_idle_bus(input string tag);
        check({tag, "_busy"}, N'(bus.busy), '0);
        check({tag, "_done"}, N'(bus.done), '0);
        check({tag, "_result"}, bus.result, '0);
        check({tag, "_cout"}, N'(bus.cout), '0);
        check({tag, "_ovf"}, N'(bus.ovf), '0);
        check({tag, "_add_a"}, N'(bus.add_a), '0);
        check({tag, "_add_b"}, N'(bus.add_b), '0);
        check({tag, "_add_cin"}, N'(bus.add_cin), '0);
    endtask

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] er;
        logic         ec;
        logic         ev;
        logic         s;
        int           n;

        tests     = 0;
        failed    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        tick;
        tick;
        check_idle_bus("reset");
        rst = 1'b0;
        tick;

        run_op(64'h00000000_FFFFFFFF, 64'h1, 1'b0, "tp_carry");
        check("tp_carry_lit", bus.result, 64'h00000001_00000000);
        run_op(64'h0, 64'h1, 1'b1, "tp_borrow");
        check("tp_borrow_lit", bus.result, 64'hFFFFFFFF_FFFFFFFF);
        check("tp_borrow_cout", N'(bus.cout), '0);
        run_op(64'h5, 64'h5, 1'b1, "tp_equal");
        check("tp_equal_lit", bus.result, 64'h0);
        check("tp_equal_cout", N'(bus.cout), N'(1'b1));
        run_op(64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, "tp_ovf");
`ifdef WIDE_ADD_SAT_EN
        check("tp_ovf_lit", bus.result, 64'h7FFFFFFF_FFFFFFFF);
`else
        check("tp_ovf_lit", bus.result, 64'h80000000_00000000);
`endif
        check("tp_ovf_flag", N'(bus.ovf), N'(1'b1));
        run_op(64'h80000000_00000000, 64'h1, 1'b1, "neg_ovf");

        for (int i = 0; i < 24; i++) begin
            for (int k = 0; k < W; k++) begin
                a[32*k +: 32] = $urandom;
                b[32*k +: 32] = $urandom;
            end
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                1: a = '1;
                2: a = {1'b0, {(N-1){1'b1}}};
                3: b = a;
                default: ;
            endcase
            run_op(a, b, s, $sformatf("rnd%0d", i));
        end

        // Start during RUN must be ignored.
        a = 64'h12345678_9ABCDEF0;
        b = 64'h0FEDCBA9_87654321;
        model(a, b, 1'b0, er, ec, ev);
        bus.op_a = a; bus.op_b = b; bus.sub = 1'b0; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        n = 0;
        while (bus.busy && n < 4 * W) begin
            if (n == 1) begin
                bus.op_a = 64'hDEAD; bus.op_b = 64'hBEEF; bus.sub = 1'b1; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            n++;
            tick;
        end
        bus.start = 1'b0;
        check("ign_cycles", N'(n), N'(W));
        check("ign_done", N'(bus.done), N'(1'b1));
        check("ign_result", bus.result, er);
        tick;
        check("ign_no_restart", N'(bus.busy), '0);
        check("ign_hold", bus.result, er);

        // Back-to-back: start held in the DONE cycle.
        bus.op_a = 64'h1; bus.op_b = 64'h2; bus.sub = 1'b0; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        n = 0;
        while (bus.busy && n < 4 * W) begin
            n++;
            tick;
        end
        check("b2b_first_done", N'(bus.done), N'(1'b1));
        check("b2b_first_result", bus.result, 64'h3);
        a = 64'hFFFFFFFF_00000000;
        b = 64'h00000001_00000001;
        model(a, b, 1'b1, er, ec, ev);
        bus.op_a = a; bus.op_b = b; bus.sub = 1'b1; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        check("b2b_busy", N'(bus.busy), N'(1'b1));
        check("b2b_cleared", bus.result, '0);
        n = 0;
        while (!bus.done && n < 4 * W) begin
            n++;
            tick;
        end
        check("b2b_latency", N'(n), N'(W));
        check("b2b_result", bus.result, er);
        check("b2b_cout", N'(bus.cout), N'(ec));
        tick;

        // Leave cout/ovf set, then abort an operation after limb 0.
        run_op(64'h80000000_00000000, 64'h80000000_00000000, 1'b0, "pre_abort");
        bus.op_a = 64'h11111111_22222222; bus.op_b = 64'h1; bus.sub = 1'b0; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_idle_bus("abort");
        tick;
        check("abort_stay_idle", N'(bus.busy), '0);
        run_op(64'h3, 64'h4, 1'b0, "post_abort");
        check("post_abort_lit", bus.result, 64'h7);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
